// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two write ports (port 1 wins collisions),
// N combinational read ports with optional same-cycle bypass, and a sequenced bulk-clear engine.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                       Clock,
   input  logic                       Reset_n,
   input  logic                       We0,
   input  logic [ADDR_W-1:0]          Waddr0,
   input  logic [DATA_W-1:0]          Wdata0,
   input  logic                       We1,
   input  logic [ADDR_W-1:0]          Waddr1,
   input  logic [DATA_W-1:0]          Wdata1,
   input  logic [NUM_RD*ADDR_W-1:0]   Raddr,
   output logic [NUM_RD*DATA_W-1:0]   Rdata,
   input  logic                       Clear,
   output logic                       Busy,
   output logic                       Conflict
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              conflict_q;
   logic              idle;
   logic              wr0_ok, wr1_ok;

   assign idle = (state_q == S_IDLE);

   // Writes to the hardwired-zero entry are dropped before they reach the array
   assign wr0_ok = idle && We0 && !((ZERO_REG != 0) && (Waddr0 == '0));
   assign wr1_ok = idle && We1 && !((ZERO_REG != 0) && (Waddr1 == '0));

   // Clear engine next-state: one entry per edge, return to IDLE after the last entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (Clear) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         conflict_q <= We0 && We1 && (Waddr0 == Waddr1);
      end
   end

   // Port 1 is written last so it overrides port 0 on an address collision
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         mem <= '{default: '0};
      end else if (state_q == S_CLEAR) begin
         mem[cnt_q] <= '0;
      end else begin
         if (wr0_ok) mem[Waddr0] <= Wdata0;
         if (wr1_ok) mem[Waddr1] <= Wdata1;
      end
   end

   logic [NUM_RD*DATA_W-1:0] rdata_c;
   logic [ADDR_W-1:0]        ra;
   logic [DATA_W-1:0]        rd;

   // Read mux: busy mask, zero entry, then bypass (port 1 first), then stored value
   always_comb begin
      rdata_c = '0;
      ra      = '0;
      rd      = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra = Raddr[k*ADDR_W +: ADDR_W];
         if (busy_q) begin
            rd = '0;
         end else if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
         end else if ((BYPASS != 0) && We1 && (Waddr1 == ra)) begin
            rd = Wdata1;
         end else if ((BYPASS != 0) && We0 && (Waddr0 == ra)) begin
            rd = Wdata0;
         end else begin
            rd = mem[ra];
         end
         rdata_c[k*DATA_W +: DATA_W] = rd;
      end
   end

   assign Rdata    = rdata_c;
   assign Busy     = busy_q;
   assign Conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (32 entries, bypass on)
// and a small instance (8 entries, bypass off) for clear and latency checks.
module tb_regfile_mp;

   logic clk;
   logic rst_n;

   // Instance A: ADDR_W=5, BYPASS=1
   logic        a_we0, a_we1;
   logic [4:0]  a_waddr0, a_waddr1;
   logic [31:0] a_wdata0, a_wdata1;
   logic [9:0]  a_raddr;
   logic [63:0] a_rdata;
   logic        a_clear, a_busy, a_conflict;

   // Instance B: ADDR_W=3, BYPASS=0
   logic        b_we0, b_we1;
   logic [2:0]  b_waddr0, b_waddr1;
   logic [31:0] b_wdata0, b_wdata1;
   logic [5:0]  b_raddr;
   logic [63:0] b_rdata;
   logic        b_clear, b_busy, b_conflict;

   int n_checks = 0;
   int n_pass   = 0;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
      .Clock(clk), .Reset_n(rst_n),
      .We0(a_we0), .Waddr0(a_waddr0), .Wdata0(a_wdata0),
      .We1(a_we1), .Waddr1(a_waddr1), .Wdata1(a_wdata1),
      .Raddr(a_raddr), .Rdata(a_rdata),
      .Clear(a_clear), .Busy(a_busy), .Conflict(a_conflict)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
      .Clock(clk), .Reset_n(rst_n),
      .We0(b_we0), .Waddr0(b_waddr0), .Wdata0(b_wdata0),
      .We1(b_we1), .Waddr1(b_waddr1), .Wdata1(b_wdata1),
      .Raddr(b_raddr), .Rdata(b_rdata),
      .Clear(b_clear), .Busy(b_busy), .Conflict(b_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      a_we0 = 0; a_we1 = 0; a_waddr0 = '0; a_waddr1 = '0; a_wdata0 = '0; a_wdata1 = '0;
      a_raddr = '0; a_clear = 0;
      b_we0 = 0; b_we1 = 0; b_waddr0 = '0; b_waddr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
      b_raddr = '0; b_clear = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset then read
      @(negedge clk); a_we0 = 1; a_waddr0 = 5'd7; a_wdata0 = 32'h0000_1234;
      @(negedge clk); a_we0 = 0; a_raddr = {5'd7, 5'd7};
      #1 check("pre_reset_rd0", a_rdata[31:0], 32'h0000_1234);
      rst_n = 1'b0;
      #1 check("reset_rd0", a_rdata[31:0], 32'h0);
      check("reset_rd1", a_rdata[63:32], 32'h0);
      check("reset_busy", 32'(a_busy), 32'h0);
      check("reset_conflict", 32'(a_conflict), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      a_we0 = 1; a_waddr0 = 5'd7; a_wdata0 = 32'hDEAD_BEEF;
      @(negedge clk); a_we0 = 0;
      #1 check("write_after_reset", a_rdata[31:0], 32'hDEAD_BEEF);

      // Collision: port 1 wins, conflict pulse for one cycle
      @(negedge clk);
      a_we0 = 1; a_we1 = 1; a_waddr0 = 5'd3; a_waddr1 = 5'd3;
      a_wdata0 = 32'h11; a_wdata1 = 32'h22; a_raddr = {5'd0, 5'd3};
      #1 check("coll_bypass", a_rdata[31:0], 32'h22);
      check("coll_conflict_before", 32'(a_conflict), 32'h0);
      @(negedge clk); a_we0 = 0; a_we1 = 0;
      #1 check("coll_conflict", 32'(a_conflict), 32'h1);
      check("coll_stored", a_rdata[31:0], 32'h22);
      @(negedge clk);
      #1 check("coll_conflict_drop", 32'(a_conflict), 32'h0);

      // Back-to-back conflicts, then a non-colliding dual write
      @(negedge clk); a_we0 = 1; a_we1 = 1; a_waddr0 = 5'd4; a_waddr1 = 5'd4;
      @(negedge clk); a_waddr0 = 5'd5; a_waddr1 = 5'd5;
      #1 check("b2b_conflict_1", 32'(a_conflict), 32'h1);
      @(negedge clk); a_waddr0 = 5'd6; a_waddr1 = 5'd8;
      #1 check("b2b_conflict_2", 32'(a_conflict), 32'h1);
      @(negedge clk); a_we0 = 0; a_we1 = 0;
      #1 check("distinct_no_conflict", 32'(a_conflict), 32'h0);

      // Zero register with bypass on
      @(negedge clk); a_we1 = 1; a_waddr1 = 5'd0; a_wdata1 = 32'hFFFF_FFFF; a_raddr = {5'd0, 5'd0};
      #1 check("zero_same_cycle", a_rdata[31:0], 32'h0);
      @(negedge clk); a_we1 = 0;
      #1 check("zero_next_cycle", a_rdata[31:0], 32'h0);

      // Bypass on (A)
      @(negedge clk); a_we0 = 1; a_waddr0 = 5'd9; a_wdata0 = 32'h77;
      @(negedge clk); a_we0 = 0; a_raddr = {5'd9, 5'd0};
      #1 check("a_old_value", a_rdata[63:32], 32'h77);
      @(negedge clk); a_we0 = 1; a_waddr0 = 5'd9; a_wdata0 = 32'h55;
      #1 check("a_bypass_same", a_rdata[63:32], 32'h55);
      @(negedge clk); a_we0 = 0;
      #1 check("a_bypass_next", a_rdata[63:32], 32'h55);

      // Bypass off (B)
      @(negedge clk); b_we0 = 1; b_waddr0 = 3'd5; b_wdata0 = 32'h77;
      @(negedge clk); b_we0 = 1; b_waddr0 = 3'd5; b_wdata0 = 32'h55; b_raddr = {3'd5, 3'd0};
      #1 check("b_no_bypass_old", b_rdata[63:32], 32'h77);
      @(negedge clk); b_we0 = 0;
      #1 check("b_no_bypass_next", b_rdata[63:32], 32'h55);

      // Bulk clear on B
      for (int j = 1; j < 8; j++) begin
         @(negedge clk); b_we0 = 1; b_waddr0 = 3'(j); b_wdata0 = 32'hA5;
      end
      @(negedge clk); b_we0 = 0; b_raddr = {3'd4, 3'd7};
      #1 check("fill_rd0", b_rdata[31:0], 32'hA5);
      check("fill_rd1", b_rdata[63:32], 32'hA5);
      b_clear = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         b_clear = 0;
         b_we0 = (i == 6); b_waddr0 = 3'd4; b_wdata0 = 32'h99;
         #1 check($sformatf("clr_busy_%0d", i), 32'(b_busy), 32'h1);
         check($sformatf("clr_mask_%0d", i), b_rdata[31:0], 32'h0);
      end
      @(negedge clk); b_we0 = 0;
      #1 check("clr_busy_done", 32'(b_busy), 32'h0);
      for (int j = 0; j < 8; j++) begin
         b_raddr = {3'(j), 3'(j)};
         #1 check($sformatf("clr_entry_%0d", j), b_rdata[31:0], 32'h0);
      end

      // Reset in the middle of a clear
      @(negedge clk); b_we0 = 1; b_waddr0 = 3'd6; b_wdata0 = 32'hA5;
      @(negedge clk); b_we0 = 0; b_clear = 1; b_raddr = {3'd0, 3'd6};
      @(negedge clk); b_clear = 0;
      repeat (3) @(negedge clk);
      #1 check("midclr_busy", 32'(b_busy), 32'h1);
      rst_n = 1'b0;
      #1 check("midclr_reset_busy", 32'(b_busy), 32'h0);
      check("midclr_reset_rd", b_rdata[31:0], 32'h0);
      @(negedge clk); rst_n = 1'b1;
      b_we0 = 1; b_waddr0 = 3'd6; b_wdata0 = 32'h42;
      #1 check("post_reset_entry6", b_rdata[31:0], 32'h0);
      @(negedge clk); b_we0 = 0;
      #1 check("post_reset_write", b_rdata[31:0], 32'h42);
      check("post_reset_busy", 32'(b_busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the single-cycle datapath, successor to the current 32x32 two-read/one-write file. It adds a configurable width, depth and read-port count, a second write port with defined collision priority, and optional write-to-read bypass. It also provides a sequenced bulk-clear engine with a busy handshake and a registered write-conflict flag. It sits between decode (read addresses) and writeback (write ports).

## Interface
- DATA_W, 32: bits per register.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: read ports, 1..4.
- ZERO_REG, 1: 1 = entry 0 hardwired to zero.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads.
- Clock  in  1  single clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- We0  in  1  write enable, port 0.
- Waddr0  in  ADDR_W  write address, port 0.
- Wdata0  in  DATA_W  write data, port 0.
- We1  in  1  write enable, port 1 (priority port).
- Waddr1  in  ADDR_W  write address, port 1.
- Wdata1  in  DATA_W  write data, port 1.
- Raddr  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
- Rdata  out  NUM_RD*DATA_W  read data; port k uses slice [k*DATA_W +: DATA_W].
- Clear  in  1  start bulk clear (level sampled; only acts in IDLE).
- Busy  out  1  clear engine active.
- Conflict  out  1  registered one-cycle pulse: both ports wrote the same address.

## Operation
- Reset (Reset_n=0, asynchronous): all entries = 0, FSM = IDLE, clear counter = 0, Busy = 0, Conflict = 0.
- Writes (IDLE only): at a rising edge, each enabled port writes its address.
  - Same address on both ports: port 1 wins.
  - ZERO_REG=1 and address 0: the write is discarded.
- Conflict: registered pulse, high for the cycle after any edge where We0 & We1 & (Waddr0==Waddr1). It fires even for address 0.
- Reads: combinational, Rdata_k = entry[Raddr_k].
  - ZERO_REG=1 and Raddr_k==0: Rdata_k = 0, never bypassed.
  - BYPASS=1 in IDLE: if We1 and Waddr1==Raddr_k, Rdata_k = Wdata1. Otherwise, if We0 and Waddr0==Raddr_k, Rdata_k = Wdata0. Otherwise, stored value.
  - BYPASS=0: stored value only; new data is visible the cycle after the write.
- Busy=1: all Rdata = 0.
- FSM states IDLE and CLEAR.
  - IDLE -> CLEAR: Clear=1 sampled at an edge. Counter is loaded with 0 and Busy=1. Writes sampled on that same edge still commit.
  - CLEAR: each edge writes 0 to entry[counter], then counter+1. Write ports and Clear are ignored.
  - CLEAR -> IDLE: on the edge that clears entry DEPTH-1. Counter wraps to 0 and Busy=0.
- Reset_n asserted mid-clear: immediate IDLE, all entries 0, Busy=0.

## Timing
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Clear sampled at edge k:
  - Busy high after edge k.
  - Entries 0..DEPTH-1 cleared at edges k+1..k+DEPTH.
  - Busy low after edge k+DEPTH.
  - Total DEPTH+1 edges from request to IDLE.
- Conflict pulse: high for exactly one cycle after the colliding edge.
- Back-to-back conflicts keep Conflict high continuously.
- Clear held high continuously restarts a clear one edge after Busy falls.
- No combinational path from Clear to Rdata or Busy; Busy is a register output.

## Test plan
- Reset then read: Reset_n=0 with Raddr all = 7 after prior writes -> every Rdata = 0, Busy=0, Conflict=0; release, write 0xDEADBEEF to 7 via port 0 -> next cycle Rdata0 = 0xDEADBEEF.
- Collision: We0=We1=1, Waddr0=Waddr1=3, Wdata0=0x11, Wdata1=0x22 -> entry 3 = 0x22; Conflict=1 for exactly the next cycle.
- Zero register: port 1 writes 0xFFFFFFFF to address 0 with BYPASS=1, Raddr0=0 -> Rdata0 = 0 in the same cycle and the next.
- Bypass: BYPASS=1, port 0 writes 0x55 to 9 while Raddr1=9 -> Rdata1 = 0x55 combinationally in the same cycle. With BYPASS=0 -> old value, then 0x55 next cycle.
- Bulk clear (ADDR_W=3): fill entries 1..7 with 0xA5; pulse Clear -> Busy high for 8 cycles, Rdata = 0 while busy. A write to 4 during busy is ignored. After Busy falls, all reads = 0.
- Reset mid-clear: assert Reset_n=0 at clear step 3 -> Busy=0 immediately; after release, reads = 0 and a normal write commits on the next edge.
